// File: rtl/mdc_timebase.sv
// MDC timebase: programmable-rate MD clock with single-cycle rise/fall strobes,
// clean start/stop on an enable, and a periodic event tick counted in MDC rising edges.
// Everything runs on `clock`; MDC is a registered data output, never used as a clock.
module mdc_timebase #(
  parameter int DIV_W    = 8,
  parameter int EVT_W    = 22,
  parameter int HALF_MIN = 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] half_per,
  input  logic [EVT_W-1:0] evt_period,
  input  logic             evt_clr,
  output logic             mdc,
  output logic             mdc_rise,
  output logic             mdc_fall,
  output logic             busy,
  output logic             evt,
  output logic [EVT_W-1:0] evt_cnt
);

  localparam logic [DIV_W-1:0] HALF_MIN_V = DIV_W'(HALF_MIN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic             mdc_q, mdc_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;
  logic             evt_q, evt_d;
  logic [EVT_W-1:0] cnt_q, cnt_d;

  logic [DIV_W-1:0] half_eff;
  logic             rise_now;

  // Clamp the requested half-period; sampled into half_q only at phase entry.
  always_comb begin
    half_eff = (half_per < HALF_MIN_V) ? HALF_MIN_V : half_per;
  end

  // Phase sequencer: next state, divider and the registered MDC/strobe values.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    state_d  = state_q;
    div_d    = div_q;
    half_d   = half_q;
    mdc_d    = mdc_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    rise_now = 1'b0;

    unique case (state_q)
      IDLE: begin
        div_d = '0;
        mdc_d = 1'b0;
        if (en) begin
          state_d = LOW;
          half_d  = half_eff;
        end
      end

      LOW: begin
        if (!en) begin
          // mdc is already low, so stopping here needs no fall strobe.
          state_d = IDLE;
          div_d   = '0;
        end else if (div_q == half_q) begin
          state_d  = HIGH;
          mdc_d    = 1'b1;
          rise_d   = 1'b1;
          rise_now = 1'b1;
          div_d    = '0;
          half_d   = half_eff;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      HIGH: begin
        // en is deliberately ignored until the high phase has run its full length.
        if (div_q == half_q) begin
          state_d = en ? LOW : IDLE;
          mdc_d   = 1'b0;
          fall_d  = 1'b1;
          div_d   = '0;
          half_d  = half_eff;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        div_d   = '0;
        mdc_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // Event counter: advances on each generated rise; a clear beats a terminal count.
  always_comb begin
    evt_d = 1'b0;
    cnt_d = cnt_q;
    if (evt_clr) begin
      cnt_d = '0;
    end else if (rise_now && (evt_period != '0)) begin
      if (cnt_q == (evt_period - EVT_W'(1))) begin
        evt_d = 1'b1;
        cnt_d = '0;
      end else begin
        // Wraps through all-ones if the period was lowered below the count.
        cnt_d = cnt_q + EVT_W'(1);
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      half_q  <= HALF_MIN_V;
      mdc_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      evt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      mdc_q   <= mdc_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      evt_q   <= evt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mdc      = mdc_q;
  assign mdc_rise = rise_q;
  assign mdc_fall = fall_q;
  assign busy     = busy_q;
  assign evt      = evt_q;
  assign evt_cnt  = cnt_q;

endmodule

// File: tb/tb_mdc_timebase.sv
// Directed bench for mdc_timebase: expected strobes (cycle, evt, evt_cnt) are
// queued as stimulus is applied and checked as the DUT emits mdc_rise/mdc_fall.
module tb_mdc_timebase;

  localparam int DIV_W = 8;
  localparam int EVT_W = 22;

  logic             clock = 1'b0;
  logic             rst;
  logic             en;
  logic [DIV_W-1:0] half_per;
  logic [EVT_W-1:0] evt_period;
  logic             evt_clr;
  logic             mdc, mdc_rise, mdc_fall, busy, evt;
  logic [EVT_W-1:0] evt_cnt;

  mdc_timebase #(.DIV_W(DIV_W), .EVT_W(EVT_W), .HALF_MIN(1)) dut (
    .clock      (clock),
    .rst        (rst),
    .en         (en),
    .half_per   (half_per),
    .evt_period (evt_period),
    .evt_clr    (evt_clr),
    .mdc        (mdc),
    .mdc_rise   (mdc_rise),
    .mdc_fall   (mdc_fall),
    .busy       (busy),
    .evt        (evt),
    .evt_cnt    (evt_cnt)
  );

  always #5 clock = ~clock;

  // Posedge count; a value registered at posedge k is seen at the following negedge with cyc == k.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit is_fall;
    int at_cyc;
    bit exp_evt;
    int exp_cnt;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", phase, tag, obs, expv);
    end
  endtask

  task automatic push(input bit is_fall, input int at_cyc, input bit e, input int n);
    exp_t x;
    x.is_fall = is_fall;
    x.at_cyc  = at_cyc;
    x.exp_evt = e;
    x.exp_cnt = n;
    exp_q.push_back(x);
  endtask

  // Advance one clock and score any strobe against the head of the queue.
  task automatic step();
    exp_t x;
    @(negedge clock);
    if (mdc_rise || mdc_fall) begin
      if (exp_q.size() == 0) begin
        check("stray_strobe", {30'd0, mdc_rise, mdc_fall}, 32'd0);
      end else begin
        x = exp_q.pop_front();
        check("strobe_kind", {30'd0, mdc_rise, mdc_fall}, x.is_fall ? 32'd1 : 32'd2);
        check("strobe_cyc", cyc, x.at_cyc);
        check("mdc_level", {31'd0, mdc}, {31'd0, ~x.is_fall});
        check("evt", {31'd0, evt}, {31'd0, x.exp_evt});
        check("evt_cnt", evt_cnt, x.exp_cnt);
      end
    end else if (evt) begin
      check("evt_without_rise", {31'd0, evt}, 32'd0);
    end
  endtask

  // Step until all queued strobes are seen or the budget runs out.
  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    check("drain_timeout_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int r;

    rst = 1'b1; en = 1'b0; half_per = 8'd9; evt_period = '0; evt_clr = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    phase = "reset";
    check("mdc", {31'd0, mdc}, 32'd0);
    check("mdc_rise", {31'd0, mdc_rise}, 32'd0);
    check("mdc_fall", {31'd0, mdc_fall}, 32'd0);
    check("busy", {31'd0, busy}, 32'd0);
    check("evt", {31'd0, evt}, 32'd0);
    check("evt_cnt", evt_cnt, 32'd0);

    // half_per=9: rise 10 clocks after en is sampled, 10 high / 10 low, evt never fires.
    phase = "basic";
    c0 = cyc; en = 1'b1;
    push(0, c0 + 11, 0, 0); push(1, c0 + 21, 0, 0);
    push(0, c0 + 31, 0, 0); push(1, c0 + 41, 0, 0);
    step();
    check("busy_running", {31'd0, busy}, 32'd1);
    drain(60);
    en = 1'b0;
    step();
    check("busy_stopped", {31'd0, busy}, 32'd0);
    check("mdc_stopped", {31'd0, mdc}, 32'd0);

    // half_per 0 and 1 both clamp to a 4-clock period.
    for (int hp = 0; hp < 2; hp++) begin
      phase = (hp == 0) ? "clamp0" : "clamp1";
      half_per = DIV_W'(hp);
      c0 = cyc; en = 1'b1;
      push(0, c0 + 3, 0, 0); push(1, c0 + 5, 0, 0);
      push(0, c0 + 7, 0, 0); push(1, c0 + 9, 0, 0);
      drain(20);
      en = 1'b0;
      step();
    end

    // half_per 9->3 mid-high: current high stays 10 clocks, following phases last 4.
    phase = "half_change";
    half_per = 8'd9;
    c0 = cyc; en = 1'b1;
    push(0, c0 + 11, 0, 0);
    drain(20);
    r = cyc;
    repeat (3) step();
    half_per = 8'd3;
    push(1, r + 10, 0, 0); push(0, r + 14, 0, 0); push(1, r + 18, 0, 0);
    drain(30);
    en = 1'b0;
    step();

    // en dropped 2 clocks into a high phase: high phase completes, then IDLE.
    phase = "drop_high";
    half_per = 8'd9;
    c0 = cyc; en = 1'b1;
    push(0, c0 + 11, 0, 0);
    drain(20);
    r = cyc;
    step(); step();
    en = 1'b0;
    push(1, r + 10, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step();
      check("mdc_held_high", {31'd0, mdc}, 32'd1);
    end
    drain(5);
    check("busy_after_fall", {31'd0, busy}, 32'd0);
    check("mdc_after_fall", {31'd0, mdc}, 32'd0);
    repeat (3) step();
    check("mdc_parked", {31'd0, mdc}, 32'd0);

    // en dropped in a low phase: immediate IDLE, no fall strobe.
    phase = "drop_low";
    en = 1'b1;
    repeat (4) step();
    check("busy_in_low", {31'd0, busy}, 32'd1);
    en = 1'b0;
    step();
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("mdc_idle", {31'd0, mdc}, 32'd0);
    repeat (12) step();
    check("mdc_idle_long", {31'd0, mdc}, 32'd0);

    // evt_period=3, half_per=1: evt_cnt 1,2,0 with evt on every 3rd rise (12 clocks).
    phase = "evt3";
    half_per = 8'd1; evt_period = 22'd3;
    evt_clr = 1'b1;
    step();
    evt_clr = 1'b0;
    check("cnt_cleared", evt_cnt, 32'd0);
    c0 = cyc; en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push(0, c0 + 3 + 4 * k, ((k + 1) % 3) == 0, (k + 1) % 3);
      push(1, c0 + 5 + 4 * k, 0, (k + 1) % 3);
    end
    drain(40);
    en = 1'b0;
    repeat (3) step();
    check("cnt_retained_idle", evt_cnt, 32'd2);

    // evt_clr on the clock that registers the terminal rise: no evt, count 0, next evt 3 rises later.
    phase = "clr_terminal";
    c0 = cyc; en = 1'b1;
    push(0, c0 + 3, 0, 0);  push(1, c0 + 5, 0, 0);
    push(0, c0 + 7, 0, 1);  push(1, c0 + 9, 0, 1);
    push(0, c0 + 11, 0, 2); push(1, c0 + 13, 0, 2);
    push(0, c0 + 15, 1, 0); push(1, c0 + 17, 0, 0);
    step(); step();
    evt_clr = 1'b1;
    step();
    evt_clr = 1'b0;
    drain(30);
    en = 1'b0;
    step();

    // rst while mdc high: everything back to reset values, no fall, then a full low phase.
    phase = "rst_high";
    half_per = 8'd9;
    c0 = cyc; en = 1'b1;
    push(0, c0 + 11, 0, 1);
    drain(20);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mdc", {31'd0, mdc}, 32'd0);
    check("busy", {31'd0, busy}, 32'd0);
    check("evt_cnt", evt_cnt, 32'd0);
    check("mdc_fall", {31'd0, mdc_fall}, 32'd0);
    c0 = cyc;
    push(0, c0 + 11, 0, 1); push(1, c0 + 21, 0, 1);
    drain(30);
    en = 1'b0;
    repeat (2) step();

    phase = "end";
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
